// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : shared types for the mic FIR scheduler
// Rev 1.0   : initial release
// ============================================================================
package audio_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int MAX_CH     = 8;
   // Channel IDs are sized for the largest legal channel count.
   localparam int CH_ID_W    = $clog2(MAX_CH);

   typedef logic [CH_ID_W-1:0] ch_id_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } fsm_state_t;
endpackage
`default_nettype wire

// File: rtl/mic_fir_scheduler_tag_fifo.sv
`default_nettype none
// ============================================================================
// tag_fifo : synchronous FIFO of channel IDs for beats inside the FIR
// Rev 1.0  : initial release
// ============================================================================
module tag_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  ch_id_t push_id,
   input  logic   pop,
   output ch_id_t pop_id,
   output logic   empty,
   output logic   full
);
   localparam int AW = $clog2(DEPTH);

   ch_id_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_id  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end
endmodule
`default_nettype wire

// File: rtl/mic_fir_scheduler.sv
`default_nettype none
// ============================================================================
// mic_fir_scheduler : round-robin sharing of one AXI-stream FIR across mics
// Rev 1.0           : initial release
// ============================================================================
module mic_fir_scheduler
   import audio_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NUM_CH-1:0]        sample_valid_in,
   input  logic [NUM_CH*DATA_W-1:0] sample_in,
   output logic                     fir_s_tvalid_out,
   input  logic                     fir_s_tready_in,
   output logic [DATA_W-1:0]        fir_s_tdata_out,
   input  logic                     fir_m_tvalid_in,
   input  logic [DATA_W-1:0]        fir_m_tdata_in,
   output logic [NUM_CH*DATA_W-1:0] filtered_out,
   output logic [NUM_CH-1:0]        filtered_valid_out,
   output logic [NUM_CH-1:0]        overrun_out,
   output logic                     tag_err_out
);
   localparam ch_id_t LAST_CH = ch_id_t'(NUM_CH - 1);

   logic [NUM_CH-1:0] pending;
   logic [DATA_W-1:0] hold [NUM_CH];
   fsm_state_t        state;
   fsm_state_t        state_nxt;
   ch_id_t            ch_q;
   ch_id_t            ptr;
   ch_id_t            grant_ch;
   ch_id_t            cand;
   ch_id_t            pop_id;
   logic              grant_found;
   logic              load;
   logic              hs;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] grant_data;
   logic [NUM_CH-1:0] is_cur;

   assign hs               = (state == ISSUE) && fir_s_tready_in;
   assign pop              = fir_m_tvalid_in && !fifo_empty;
   assign fir_s_tvalid_out = (state == ISSUE);
   assign fir_s_tdata_out  = data_q;

   // Round-robin search begins one past the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_ch    = '0;
      grant_data  = '0;
      cand        = ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_found && cand == ch_id_t'(k) && pending[k]) begin
               grant_found = 1'b1;
               grant_ch    = cand;
               grant_data  = hold[k];
            end
         end
      end
      for (int k = 0; k < NUM_CH; k++) is_cur[k] = (ch_q == ch_id_t'(k));
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found && !fifo_full) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (fir_s_tready_in) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state  <= IDLE;
         ch_q   <= '0;
         ptr    <= '0;
         data_q <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            ch_q   <= grant_ch;
            ptr    <= grant_ch;
            data_q <= grant_data;
         end
      end
   end

   // A capture that coincides with its own channel's handshake keeps pending set.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pending     <= '0;
         overrun_out <= '0;
         for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sample_valid_in[k]) begin
               hold[k]    <= sample_in[k*DATA_W +: DATA_W];
               pending[k] <= 1'b1;
               if (pending[k] && !(hs && is_cur[k])) overrun_out[k] <= 1'b1;
            end else if (hs && is_cur[k]) begin
               pending[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         filtered_out       <= '0;
         filtered_valid_out <= '0;
         tag_err_out        <= 1'b0;
      end else begin
         if (fir_m_tvalid_in && fifo_empty) tag_err_out <= 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            filtered_valid_out[k] <= pop && (pop_id == ch_id_t'(k));
            if (pop && (pop_id == ch_id_t'(k)))
               filtered_out[k*DATA_W +: DATA_W] <= fir_m_tdata_in;
         end
      end
   end

   tag_fifo #(
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk     (clk_in),
      .rst     (rst_in),
      .push    (hs),
      .push_id (ch_q),
      .pop     (pop),
      .pop_id  (pop_id),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );
endmodule
`default_nettype wire

// File: tb/tb_mic_fir_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mic_fir_scheduler : scoreboard bench with a transaction-level model
// Rev 1.0              : initial release
// ============================================================================
module tb_mic_fir_scheduler;
   localparam int NUM_CH  = 3;
   localparam int DATA_W  = 16;
   localparam int MAX_INF = 4;
   localparam int FIR_LAT = 5;

   logic                     clk = 1'b0;
   logic                     rst_in;
   logic [NUM_CH-1:0]        sample_valid_in;
   logic [NUM_CH*DATA_W-1:0] sample_in;
   logic                     fir_s_tvalid_out;
   logic                     fir_s_tready_in;
   logic [DATA_W-1:0]        fir_s_tdata_out;
   logic                     fir_m_tvalid_in;
   logic [DATA_W-1:0]        fir_m_tdata_in;
   logic [NUM_CH*DATA_W-1:0] filtered_out;
   logic [NUM_CH-1:0]        filtered_valid_out;
   logic [NUM_CH-1:0]        overrun_out;
   logic                     tag_err_out;

   mic_fir_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INF)) dut (
      .clk_in             (clk),
      .rst_in             (rst_in),
      .sample_valid_in    (sample_valid_in),
      .sample_in          (sample_in),
      .fir_s_tvalid_out   (fir_s_tvalid_out),
      .fir_s_tready_in    (fir_s_tready_in),
      .fir_s_tdata_out    (fir_s_tdata_out),
      .fir_m_tvalid_in    (fir_m_tvalid_in),
      .fir_m_tdata_in     (fir_m_tdata_in),
      .filtered_out       (filtered_out),
      .filtered_valid_out (filtered_valid_out),
      .overrun_out        (overrun_out),
      .tag_err_out        (tag_err_out)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DATA_W-1:0] data; int due; } fir_beat_t;
   typedef struct { int ch; logic [DATA_W-1:0] data; } exp_t;

   // Reference model: per-channel mailbox of newest sample plus the beat in flight.
   logic [DATA_W-1:0] m_hold [NUM_CH];
   bit                m_pend [NUM_CH];
   bit                m_ovr  [NUM_CH];
   bit                m_terr;
   bit                m_busy;
   int                m_ch;
   int                m_ptr;
   logic [DATA_W-1:0] m_data;
   int                tags[$];
   fir_beat_t         fir_q[$];
   exp_t              exp_q[$];
   logic [DATA_W-1:0] obs_log[$];

   int cyc;
   bit fir_stall, spurious, tready_low, tready_rand;
   int compared, mismatched;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit outputs_zero();
      return fir_s_tvalid_out == 1'b0 && fir_s_tdata_out == '0 && filtered_out == '0 &&
             filtered_valid_out == '0 && overrun_out == '0 && tag_err_out == 1'b0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NUM_CH; k++) begin
         m_hold[k] = '0; m_pend[k] = 0; m_ovr[k] = 0;
      end
      m_terr = 0; m_busy = 0; m_ch = 0; m_ptr = 0; m_data = '0;
      tags.delete(); fir_q.delete(); exp_q.delete(); obs_log.delete();
      fir_stall = 0; spurious = 0; tready_low = 0; tready_rand = 0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      sample_valid_in = '0; sample_in = '0;
      fir_s_tready_in = 1'b0; fir_m_tvalid_in = 1'b0; fir_m_tdata_in = '0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      check("reset_state", outputs_zero(), 1'b1);
      rst_in = 1'b0;
   endtask

   task automatic strobe(input int ch, input logic [DATA_W-1:0] val);
      sample_valid_in[ch] = 1'b1;
      sample_in[ch*DATA_W +: DATA_W] = val;
   endtask

   task automatic tick();
      bit hs, grant;
      int g, c;
      fir_beat_t b;
      exp_t e;
      logic [NUM_CH-1:0] ovr_vec;
      fir_m_tvalid_in = 1'b0;
      fir_m_tdata_in  = '0;
      if (spurious) begin
         fir_m_tvalid_in = 1'b1; fir_m_tdata_in = 16'hDEAD; spurious = 0;
      end else if (!fir_stall && fir_q.size() > 0 && fir_q[0].due <= cyc) begin
         b = fir_q.pop_front();
         fir_m_tvalid_in = 1'b1; fir_m_tdata_in = b.data;
      end
      fir_s_tready_in = tready_low ? 1'b0 : (tready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (fir_s_tvalid_out && fir_s_tready_in) obs_log.push_back(fir_s_tdata_out);

      hs = m_busy && fir_s_tready_in;
      grant = 0; g = 0;
      if (!m_busy && tags.size() < MAX_INF)
         for (int i = 1; i <= NUM_CH; i++) begin
            c = (m_ptr + i) % NUM_CH;
            if (!grant && m_pend[c]) begin grant = 1; g = c; end
         end
      if (fir_m_tvalid_in) begin
         if (tags.size() > 0) begin
            e.ch = tags.pop_front(); e.data = fir_m_tdata_in;
            exp_q.push_back(e);
         end else m_terr = 1;
      end
      if (hs) begin
         tags.push_back(m_ch);
         b.data = m_data; b.due = cyc + FIR_LAT;
         fir_q.push_back(b);
         m_pend[m_ch] = 0; m_busy = 0;
      end
      if (grant) begin
         m_busy = 1; m_ch = g; m_ptr = g; m_data = m_hold[g];
      end
      for (int k = 0; k < NUM_CH; k++)
         if (sample_valid_in[k]) begin
            if (m_pend[k]) m_ovr[k] = 1;
            m_hold[k] = sample_in[k*DATA_W +: DATA_W];
            m_pend[k] = 1;
         end

      @(posedge clk);
      cyc++;
      #1;
      sample_valid_in = '0;
      for (int k = 0; k < NUM_CH; k++) ovr_vec[k] = m_ovr[k];
      check("tvalid", fir_s_tvalid_out, m_busy);
      if (m_busy) check("tdata", fir_s_tdata_out, m_data);
      check("overrun", overrun_out, ovr_vec);
      check("tag_err", tag_err_out, m_terr);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: every filtered strobe must match the oldest predicted result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_in && filtered_valid_out != '0) begin
            if (exp_q.size() == 0) check("unexpected_strobe", filtered_valid_out, '0);
            else begin
               e = exp_q.pop_front();
               check("strobe_ch", filtered_valid_out, 64'(1) << e.ch);
               check("filtered_val", filtered_out[e.ch*DATA_W +: DATA_W], e.data);
            end
         end
      end
   end

   initial begin
      compared = 0; mismatched = 0; cyc = 0;
      do_reset();

      // single channel latency and routing
      strobe(1, 16'h1234); tick(); tick();
      check("single_tvalid", fir_s_tvalid_out, 1'b1);
      check("single_tdata", fir_s_tdata_out, 16'h1234);
      run(12);
      check("single_filtered", filtered_out, {16'h0000, 16'h1234, 16'h0000});

      // fairness from ptr = 0
      do_reset();
      strobe(0, 16'h0001); strobe(1, 16'h0002); strobe(2, 16'h0003); tick();
      run(20);
      check("rr_count", obs_log.size(), 3);
      if (obs_log.size() == 3) begin
         check("rr_first", obs_log[0], 16'h0002);
         check("rr_second", obs_log[1], 16'h0003);
         check("rr_third", obs_log[2], 16'h0001);
      end
      check("rr_filtered", filtered_out, {16'h0003, 16'h0002, 16'h0001});

      // back-pressure
      do_reset();
      tready_low = 1; strobe(0, 16'hBEEF); tick(); tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_stable", {fir_s_tvalid_out, fir_s_tdata_out}, {1'b1, 16'hBEEF});
      end
      check("bp_no_push", obs_log.size(), 0);
      tready_low = 0; tick();
      check("bp_one_push", obs_log.size(), 1);
      run(10);
      check("bp_still_one", obs_log.size(), 1);

      // overrun while another channel is stalled
      do_reset();
      tready_low = 1; strobe(0, 16'h0AAA); tick(); tick();
      strobe(2, 16'h1111); tick();
      strobe(2, 16'h2222); tick();
      check("ovr_set", overrun_out, 3'b100);
      tready_low = 0; run(20);
      check("ovr_issued", {obs_log.size() == 2 ? obs_log[1] : 16'h0}, 16'h2222);

      // capture coincident with its own handshake
      do_reset();
      tready_low = 1; strobe(2, 16'h3333); tick(); tick();
      tready_low = 0; strobe(2, 16'h4444); tick();
      check("coincide_no_ovr", overrun_out[2], 1'b0);
      run(20);
      check("coincide_count", obs_log.size(), 2);
      check("coincide_second", {obs_log.size() == 2 ? obs_log[1] : 16'h0}, 16'h4444);

      // in-flight limit
      do_reset();
      fir_stall = 1;
      strobe(0, 16'h0010); strobe(1, 16'h0011); strobe(2, 16'h0012); tick();
      run(10);
      strobe(0, 16'h0020); strobe(1, 16'h0021); strobe(2, 16'h0022); tick();
      run(30);
      check("inflight_cap", obs_log.size(), MAX_INF);
      check("inflight_blocked", fir_s_tvalid_out, 1'b0);
      fir_stall = 0; run(3);
      check("inflight_resume", obs_log.size(), MAX_INF + 1);
      run(30);
      check("inflight_all", obs_log.size(), 6);

      // spurious result, then reset mid-ISSUE
      do_reset();
      spurious = 1; tick();
      check("spur_err", tag_err_out, 1'b1);
      tick();
      check("spur_no_strobe", filtered_valid_out, '0);
      tready_low = 1; strobe(1, 16'h5555); tick(); tick();
      check("pre_rst_issue", fir_s_tvalid_out, 1'b1);
      #2 rst_in = 1'b1;
      #1 check("async_reset", outputs_zero(), 1'b1);
      do_reset();

      // randomized traffic with FIR stalls and random back-pressure
      tready_rand = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 16 == 0) fir_stall = ($urandom_range(0, 99) < 25);
         for (int k = 0; k < NUM_CH; k++)
            if ($urandom_range(0, 7) == 0) strobe(k, 16'($urandom));
         tick();
      end
      fir_stall = 0; tready_rand = 0; run(80);
      check("drain_results", exp_q.size(), 0);
      check("drain_tags", tags.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
